// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-side hazard/forwarding unit.
// Build option HAZ_FWD_EN (see hazard_forward_unit) selects forwarding or full interlock.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             wr;
        logic             ld;
    } ex_slot_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             wr;
    } mem_slot_t;

    // XZR is never a real producer, so it can never create a dependency.
    function automatic logic slot_hit(input logic [REG_W-1:0] src,
                                      input logic             v,
                                      input logic             wr,
                                      input logic [REG_W-1:0] dest);
        return v & wr & (src == dest) & (src != ZERO_REG);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_src_match.sv
// Compares one ID source register against the EX and MEM shadow slots.
module src_match
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  ex_slot_t         ex,
    input  mem_slot_t        mem,
    output logic             hit_ex,
    output logic             hit_mem,
    output logic             load_hit
);

    assign hit_ex   = slot_hit(src, ex.v, ex.wr, ex.dest);
    assign hit_mem  = slot_hit(src, mem.v, mem.wr, mem.dest);
    assign load_hit = hit_ex & ex.ld;

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: shadow EX/MEM slots, load-use stall, registered forward selects.
// `define HAZ_FWD_EN enables forwarding; otherwise the unit is a full interlock.
module hazard_forward_unit
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b
);

    ex_slot_t  ex_q;
    mem_slot_t mem_q;

    logic hit_ex_rn, hit_mem_rn, load_hit_rn;
    logic hit_ex_rm, hit_mem_rm, load_hit_rm;
    logic issue;

    src_match u_match_rn (
        .src      (id_rn),
        .ex       (ex_q),
        .mem      (mem_q),
        .hit_ex   (hit_ex_rn),
        .hit_mem  (hit_mem_rn),
        .load_hit (load_hit_rn)
    );

    src_match u_match_rm (
        .src      (id_rm),
        .ex       (ex_q),
        .mem      (mem_q),
        .hit_ex   (hit_ex_rm),
        .hit_mem  (hit_mem_rm),
        .load_hit (load_hit_rm)
    );

    // A stalled or flushed instruction becomes a bubble with no write side effects.
    assign issue = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= '{v: ex_q.v, dest: ex_q.dest, wr: ex_q.wr};
            ex_q  <= '{v: issue, dest: id_dest,
                       wr: id_reg_write & issue, ld: id_mem_read & issue};
        end
    end

`ifdef HAZ_FWD_EN

    fwd_sel_t fwd_a_nxt, fwd_b_nxt;

    function automatic fwd_sel_t pick_src(input logic used,
                                          input logic bubble,
                                          input logic hit_ex,
                                          input logic hit_mem);
        if (!used || bubble) return FWD_RF;
        if (hit_ex)          return FWD_EXMEM;
        if (hit_mem)         return FWD_MEMWB;
        return FWD_RF;
    endfunction

    // Only a load in EX cannot be forwarded in time; everything else bypasses.
    assign stall = id_valid & ~flush &
                   ((id_use_rn & load_hit_rn) | (id_use_rm & load_hit_rm));

    always_comb begin
        fwd_a_nxt = pick_src(id_use_rn, stall | flush, hit_ex_rn, hit_mem_rn);
        fwd_b_nxt = pick_src(id_use_rm, stall | flush, hit_ex_rm, hit_mem_rm);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            fwd_a <= fwd_a_nxt;
            fwd_b <= fwd_b_nxt;
        end
    end

`else

    logic unused_load_hits;

    // Without bypass paths any in-flight producer must drain through writeback.
    assign stall = id_valid & ~flush &
                   ((id_use_rn & (hit_ex_rn | hit_mem_rn)) |
                    (id_use_rm & (hit_ex_rm | hit_mem_rm)));

    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
    assign unused_load_hits = &{1'b0, load_hit_rn, load_hit_rm};

`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit with an in-bench pipeline-history model.
`timescale 1ns/1ps
module tb_hazard_forward_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rn = '0, id_rm = '0, id_dest = '0;
    logic       id_use_rn = 1'b0, id_use_rm = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic       stall;
    fwd_sel_t   fwd_a, fwd_b;

    hazard_forward_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: list of issued instructions, newest first; index 0 is in EX, 1 is in MEM.
    typedef struct {
        bit v;
        int dest;
        bit wr;
        bit ld;
    } ent_t;

    ent_t hist[$];
    int   exp_a = 0;
    int   exp_b = 0;

    function automatic bit produces(int s, int age);
        return hist[age].v && hist[age].wr && hist[age].dest == s && s != 31;
    endfunction

    function automatic bit m_stall();
        if (!id_valid || flush) return 1'b0;
`ifdef HAZ_FWD_EN
        return (id_use_rn && produces(int'(id_rn), 0) && hist[0].ld) ||
               (id_use_rm && produces(int'(id_rm), 0) && hist[0].ld);
`else
        return (id_use_rn && (produces(int'(id_rn), 0) || produces(int'(id_rn), 1))) ||
               (id_use_rm && (produces(int'(id_rm), 0) || produces(int'(id_rm), 1)));
`endif
    endfunction

`ifdef HAZ_FWD_EN
    function automatic int m_sel(bit used, int s, bit st);
        if (!used || st || flush) return 0;
        if (produces(s, 0)) return 1;
        if (produces(s, 1)) return 2;
        return 0;
    endfunction
`endif

    always @(posedge clk or negedge rst_n) begin : model
        bit   st;
        ent_t e;
        if (!rst_n) begin
            hist = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
            exp_a = 0;
            exp_b = 0;
        end else begin
            st = m_stall();
`ifdef HAZ_FWD_EN
            exp_a = m_sel(id_use_rn, int'(id_rn), st);
            exp_b = m_sel(id_use_rm, int'(id_rm), st);
`else
            exp_a = 0;
            exp_b = 0;
`endif
            e.v    = id_valid && !st && !flush;
            e.dest = int'(id_dest);
            e.wr   = id_reg_write && e.v;
            e.ld   = id_mem_read && e.v;
            hist.push_front(e);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_stall", stall, m_stall());
            chk("model_fwd_a", fwd_a, exp_a);
            chk("model_fwd_b", fwd_b, exp_b);
        end
    end

    task automatic cyc(input bit v, input int rn, input int rm, input bit urn, input bit urm,
                       input int dest, input bit wr, input bit ld, input bit fl,
                       input int exp_st, input string nm);
        id_valid = v; id_rn = rn[4:0]; id_rm = rm[4:0];
        id_use_rn = urn; id_use_rm = urm; id_dest = dest[4:0];
        id_reg_write = wr; id_mem_read = ld; flush = fl;
        @(negedge clk); #1;
        if (exp_st >= 0) chk({nm, "_stall"}, stall, exp_st);
        @(posedge clk); #1;
    endtask

    task automatic op(input int rn, input int rm, input int dest, input int exp_st, input string nm);
        cyc(1, rn, rm, 1, 1, dest, 1, 0, 0, exp_st, nm);
    endtask

    task automatic ldr(input int rn, input int dest, input int exp_st, input string nm);
        cyc(1, rn, 0, 1, 0, dest, 1, 1, 0, exp_st, nm);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, "idle");
    endtask

    task automatic fwd_is(input string nm, input int a, input int b);
        chk({nm, "_fwd_a"}, fwd_a, a);
        chk({nm, "_fwd_b"}, fwd_b, b);
    endtask

    initial begin
        hist = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        fwd_is("rst", 0, 0);
        rst_n = 1'b1;
        idle();

`ifdef HAZ_FWD_EN
        op(2, 3, 1, 0, "add_x1");
        op(1, 5, 2, 0, "sub_x2");
        fwd_is("raw_ex", 1, 0);

        idle(); idle();
        op(2, 3, 1, 0, "add_x1");
        op(10, 11, 9, 0, "orr_x9");
        op(6, 1, 4, 0, "and_x4");
        fwd_is("raw_mem", 0, 2);

        idle(); idle();
        op(2, 3, 1, 0, "add_x1a");
        op(2, 3, 1, 0, "add_x1b");
        op(6, 1, 4, 0, "and_new");
        fwd_is("newest", 0, 1);

        idle(); idle();
        ldr(2, 7, 0, "ldur_x7");
        op(7, 7, 8, 1, "ldu_1");
        fwd_is("ldu_bubble", 0, 0);
        chk("bubble_v", dut.ex_q.v, 0);
        chk("bubble_wr", dut.ex_q.wr, 0);
        op(7, 7, 8, 0, "ldu_2");
        fwd_is("ldu_after", 2, 2);

        idle(); idle();
        op(2, 3, 31, 0, "wr_xzr");
        op(31, 31, 2, 0, "rd_xzr");
        fwd_is("xzr_alu", 0, 0);
        ldr(2, 31, 0, "ld_xzr");
        op(31, 31, 2, 0, "rd_xzr_ld");
        fwd_is("xzr_ld", 0, 0);

        idle(); idle();
        ldr(2, 3, 0, "ldur_x3");
        cyc(1, 3, 0, 1, 0, 4, 1, 0, 1, 0, "flush_ldu");
        chk("flush_ex_v", dut.ex_q.v, 0);
        fwd_is("flush", 0, 0);

        idle(); idle();
        op(2, 3, 1, 0, "pre_rst_add");
        ldr(1, 3, 0, "pre_rst_ld");
        chk("pre_rst_fwd_a", fwd_a, 1);
`else
        op(2, 3, 1, 0, "add_x1");
        op(1, 5, 2, 1, "sub_s1");
        fwd_is("il_s1", 0, 0);
        op(1, 5, 2, 1, "sub_s2");
        fwd_is("il_s2", 0, 0);
        op(1, 5, 2, 0, "sub_go");
        fwd_is("il_go", 0, 0);

        idle(); idle();
        op(2, 3, 1, 0, "add_x1");
        op(10, 11, 9, 0, "orr_x9");
        op(6, 1, 4, 1, "and_s1");
        op(6, 1, 4, 0, "and_go");

        idle(); idle();
        ldr(2, 7, 0, "ldur_x7");
        op(7, 7, 8, 1, "ldu_s1");
        op(7, 7, 8, 1, "ldu_s2");
        op(7, 7, 8, 0, "ldu_go");

        idle(); idle();
        op(2, 3, 31, 0, "wr_xzr");
        op(31, 31, 2, 0, "rd_xzr");

        idle(); idle();
        op(2, 3, 1, 0, "add_x1");
        cyc(1, 1, 0, 1, 0, 4, 1, 0, 1, 0, "flush_raw");
        chk("flush_ex_v", dut.ex_q.v, 0);

        idle(); idle();
        ldr(2, 3, 0, "pre_rst_ld");
`endif
        // Reader of X3 while the load sits in EX, then reset mid-cycle.
        id_valid = 1; id_rn = 5'd3; id_rm = 5'd5; id_use_rn = 1; id_use_rm = 1;
        id_dest = 5'd4; id_reg_write = 1; id_mem_read = 0; flush = 0;
        @(negedge clk); #1;
        chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", stall, 0);
        fwd_is("async_rst", 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_stall", stall, 0);
        @(posedge clk); #1;
        fwd_is("post_rst", 0, 0);

        idle(); idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
